rx_serial_param: RTL and testbench

- Parametrised UART receiver: self-timed FSM with integrated bit-rate counter, input synchroniser and data/error holding registers.
- Replaces the fixed 8N1 control unit with external tick. Supports 5–9 data bits, none/odd/even parity, 1–2 stop bits and false-start rejection.
- Sits between the RX pin and the movement-decoding logic.
- Delivers one word per frame with a single-cycle pronto pulse.

---
 rtl/rx_serial_param.sv | 200 ++++++++++++++++++++
 tb/tb_rx_serial_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_param.sv
`timescale 1ns/1ps
// rx_serial_param: UART receiver with its own bit-rate counter, RX synchroniser
// and held data/error outputs; configurable data width, parity and stop bits.
module rx_serial_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] dados,
  output logic                 pronto,
  output logic                 erro_paridade,
  output logic                 erro_parada,
  output logic                 ocupado,
  output logic [3:0]           db_estado
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    START     = 4'h1,
    DADOS     = 4'h2,
    PARIDADE  = 4'h3,
    PARADA    = 4'h4,
    REGISTRAR = 4'h9,
    FINAL_RX  = 4'hF
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_prev_reg;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [BW-1:0]          bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_err_reg, par_err_next;
  logic                   stop_err_reg, stop_err_next;
  logic [DATA_BITS-1:0]   dados_reg, dados_next;
  logic                   erro_par_reg, erro_par_next;
  logic                   erro_stop_reg, erro_stop_next;

  logic rx_s;
  logic rx_fall;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg    <= '1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], RX};
      rx_prev_reg <= rx_s;
    end
  end

  assign rx_s    = sync_reg[SYNC_STAGES-1];
  assign rx_fall = rx_prev_reg & ~rx_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= INICIAL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      par_err_reg   <= 1'b0;
      stop_err_reg  <= 1'b0;
      dados_reg     <= '0;
      erro_par_reg  <= 1'b0;
      erro_stop_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      par_err_reg   <= par_err_next;
      stop_err_reg  <= stop_err_next;
      dados_reg     <= dados_next;
      erro_par_reg  <= erro_par_next;
      erro_stop_reg <= erro_stop_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    par_err_next   = par_err_reg;
    stop_err_next  = stop_err_reg;
    dados_next     = dados_reg;
    erro_par_next  = erro_par_reg;
    erro_stop_next = erro_stop_reg;

    case (state_reg)
      INICIAL: begin
        cnt_next = '0;
        bit_next = '0;
        if (rx_fall) begin
          // Flags describe only the frame now starting.
          par_err_next  = 1'b0;
          stop_err_next = 1'b0;
          state_next    = START;
        end
      end

      START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rx_s ? INICIAL : DADOS;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DADOS: begin
        if (cnt_reg == CNT_FULL) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == LAST_DATA) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? PARIDADE : PARADA;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      PARIDADE: begin
        if (cnt_reg == CNT_FULL) begin
          cnt_next = '0;
          if (PARITY == 1) begin
            par_err_next = ~((^shift_reg) ^ rx_s);
          end else begin
            par_err_next = (^shift_reg) ^ rx_s;
          end
          state_next = PARADA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      PARADA: begin
        if (cnt_reg == CNT_FULL) begin
          cnt_next = '0;
          if (!rx_s) begin
            stop_err_next = 1'b1;
          end
          if (bit_reg == LAST_STOP) begin
            state_next = REGISTRAR;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      REGISTRAR: begin
        dados_next     = shift_reg;
        erro_par_next  = par_err_reg;
        erro_stop_next = stop_err_reg;
        state_next     = FINAL_RX;
      end

      FINAL_RX: begin
        state_next = INICIAL;
      end

      default: begin
        state_next = INICIAL;
      end
    endcase
  end

  assign dados         = dados_reg;
  assign erro_paridade = erro_par_reg;
  assign erro_parada   = erro_stop_reg;
  assign pronto        = (state_reg == FINAL_RX);
  assign ocupado       = (state_reg != INICIAL);
  assign db_estado     = state_reg;

endmodule

// File: tb/tb_rx_serial_param.sv
`timescale 1ns/1ps
// Bench for rx_serial_param: four receiver configurations driven with directed
// and random frames, checked against a frame-level expectation model.
module tb_rx_serial_param;

  localparam int NDUT = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NDUT-1:0] rx_v  = '1;

  wire  [NDUT-1:0] pronto_v, ep_v, es_v, ocup_v;
  wire  [3:0]      st_a [NDUT];
  wire  [7:0]      dados0;
  wire  [6:0]      dados1;
  wire  [5:0]      dados2;
  wire  [8:0]      dados3;
  wire  [8:0]      dv [NDUT];

  assign dv[0] = {1'b0, dados0};
  assign dv[1] = {2'b0, dados1};
  assign dv[2] = {3'b0, dados2};
  assign dv[3] = dados3;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  rx_serial_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_d0 (
    .clock(clock), .reset(reset), .RX(rx_v[0]), .dados(dados0), .pronto(pronto_v[0]),
    .erro_paridade(ep_v[0]), .erro_parada(es_v[0]), .ocupado(ocup_v[0]), .db_estado(st_a[0]));

  rx_serial_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_d1 (
    .clock(clock), .reset(reset), .RX(rx_v[1]), .dados(dados1), .pronto(pronto_v[1]),
    .erro_paridade(ep_v[1]), .erro_parada(es_v[1]), .ocupado(ocup_v[1]), .db_estado(st_a[1]));

  rx_serial_param #(.DATA_BITS(6), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_d2 (
    .clock(clock), .reset(reset), .RX(rx_v[2]), .dados(dados2), .pronto(pronto_v[2]),
    .erro_paridade(ep_v[2]), .erro_parada(es_v[2]), .ocupado(ocup_v[2]), .db_estado(st_a[2]));

  rx_serial_param #(.DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(5), .SYNC_STAGES(3)) u_d3 (
    .clock(clock), .reset(reset), .RX(rx_v[3]), .dados(dados3), .pronto(pronto_v[3]),
    .erro_paridade(ep_v[3]), .erro_parada(es_v[3]), .ocupado(ocup_v[3]), .db_estado(st_a[3]));

  function automatic int cfg_data(input int d);
    case (d)
      0: return 8;
      1: return 7;
      2: return 6;
      default: return 9;
    endcase
  endfunction

  function automatic int cfg_par(input int d);
    case (d)
      1: return 1;
      2: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_stop(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic int cfg_cpb(input int d);
    return (d == 3) ? 5 : 16;
  endfunction

  function automatic int cfg_sync(input int d);
    return (d == 3) ? 3 : 2;
  endfunction

  typedef struct {
    int         dut;
    int         cyc;
    logic [8:0] data;
    logic       ep;
    logic       es;
  } evt_t;

  evt_t obs_q[$];
  evt_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Every pronto pulse is logged with the cycle it was seen and the held outputs.
  always @(negedge clock) begin
    for (int d = 0; d < NDUT; d++) begin
      if (pronto_v[d] === 1'b1) begin
        obs_q.push_back('{d, cyc, dv[d], ep_v[d], es_v[d]});
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic verify_events(input string tag);
    int n;
    check_val({tag, ":count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      $display("frame %s dut=%0d cyc=%0d dados=%0h erro_paridade=%0b erro_parada=%0b",
               tag, obs_q[i].dut, obs_q[i].cyc, obs_q[i].data, obs_q[i].ep, obs_q[i].es);
      check_val($sformatf("%s[%0d]:dut", tag, i),  32'(obs_q[i].dut),  32'(exp_q[i].dut));
      check_val($sformatf("%s[%0d]:cyc", tag, i),  32'(obs_q[i].cyc),  32'(exp_q[i].cyc));
      check_val($sformatf("%s[%0d]:data", tag, i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      check_val($sformatf("%s[%0d]:ep", tag, i),   32'(obs_q[i].ep),   32'(exp_q[i].ep));
      check_val($sformatf("%s[%0d]:es", tag, i),   32'(obs_q[i].es),   32'(exp_q[i].es));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Drive one line level for n clocks; returns one time unit after a rising edge.
  task automatic hold(input int d, input logic b, input int n);
    rx_v[d] = b;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame model: the receiver delivers the driven data bits, flags parity from
  // the count of ones, flags stop if any stop bit was low, and pronto appears
  // sync + half-bit + (bits after start) * bit-time + 2 cycles after the line falls.
  task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input int gap);
    int         nd, np, ns, cpb, ones;
    logic [8:0] w;
    evt_t       e;
    nd  = cfg_data(d);
    np  = (cfg_par(d) != 0) ? 1 : 0;
    ns  = cfg_stop(d);
    cpb = cfg_cpb(d);
    w   = '0;
    for (int i = 0; i < nd; i++) w[i] = data[i];
    ones = $countones(w) + ((np != 0 && pbit) ? 1 : 0);
    e.dut  = d;
    e.cyc  = cyc + cfg_sync(d) + cpb / 2 + (nd + np + ns) * cpb + 2;
    e.data = w;
    e.ep   = (cfg_par(d) == 1) ? ((ones % 2) == 0) :
             (cfg_par(d) == 2) ? ((ones % 2) == 1) : 1'b0;
    e.es   = 1'b0;
    for (int i = 0; i < ns; i++) if (!stops[i]) e.es = 1'b1;
    exp_q.push_back(e);
    hold(d, 1'b0, cpb);
    for (int i = 0; i < nd; i++) hold(d, w[i], cpb);
    if (np != 0) hold(d, pbit, cpb);
    for (int i = 0; i < ns; i++) hold(d, stops[i], cpb);
    if (gap > 0) hold(d, 1'b1, gap);
  endtask

  initial begin
    int         n_start, max_st, bad_ocup, gap, c0;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    evt_t       e;

    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check_val($sformatf("rst_dados%0d", d),  32'(dv[d]),       32'h0);
      check_val($sformatf("rst_pronto%0d", d), 32'(pronto_v[d]), 32'h0);
      check_val($sformatf("rst_ep%0d", d),     32'(ep_v[d]),     32'h0);
      check_val($sformatf("rst_es%0d", d),     32'(es_v[d]),     32'h0);
      check_val($sformatf("rst_ocup%0d", d),   32'(ocup_v[d]),   32'h0);
      check_val($sformatf("rst_state%0d", d),  32'(st_a[d]),     32'h0);
    end
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // 8N1 back-to-back
    send_frame(0, 9'h055, 1'b0, 2'b11, 0);
    send_frame(0, 9'h0A3, 1'b0, 2'b11, 0);
    hold(0, 1'b1, 20);
    verify_events("8n1");

    // short low pulse must be rejected in START
    n_start = 0; max_st = 0; bad_ocup = 0;
    rx_v[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) rx_v[0] = 1'b1;
      @(negedge clock);
      if (st_a[0] == 4'h1) n_start++;
      if (int'(st_a[0]) > max_st) max_st = int'(st_a[0]);
      if (ocup_v[0] !== (st_a[0] != 4'h0)) bad_ocup++;
      @(posedge clock);
      #1;
    end
    check_val("glitch_start_cycles", 32'(n_start), 32'd8);
    check_val("glitch_max_state",    32'(max_st),  32'd1);
    check_val("glitch_ocupado",      32'(bad_ocup), 32'd0);
    check_val("glitch_end_state",    32'(st_a[0]), 32'h0);
    verify_events("glitch");

    // odd parity, 7 data bits
    send_frame(1, 9'h041, 1'b1, 2'b11, 4);
    send_frame(1, 9'h041, 1'b0, 2'b11, 4);
    hold(1, 1'b1, 20);
    verify_events("odd_par");

    // two stop bits, second one low, then a clean frame clears the flag
    send_frame(2, 9'h00F, 1'b0, 2'b01, 3);
    send_frame(2, 9'h03C, 1'b0, 2'b11, 3);
    hold(2, 1'b1, 20);
    verify_events("stop2");

    // break: line low for 20 bit times gives exactly one frame
    e.dut = 0; e.cyc = cyc + 2 + 8 + 9 * 16 + 2; e.data = '0; e.ep = 1'b0; e.es = 1'b1;
    exp_q.push_back(e);
    hold(0, 1'b0, 20 * 16);
    check_val("break_state", 32'(st_a[0]), 32'h0);
    check_val("break_ocup",  32'(ocup_v[0]), 32'h0);
    hold(0, 1'b1, 40);
    verify_events("break");
    send_frame(0, 9'h05A, 1'b0, 2'b11, 20);
    verify_events("recover");

    // reset pulse in the middle of the data bits
    hold(0, 1'b0, 16);
    hold(0, 1'b1, 16);
    hold(0, 1'b0, 8);
    check_val("midrst_pre_state", 32'(st_a[0]), 32'h2);
    reset   = 1'b0;
    rx_v[0] = 1'b1;
    #1;
    check_val("midrst_dados",  32'(dv[0]),       32'h0);
    check_val("midrst_pronto", 32'(pronto_v[0]), 32'h0);
    check_val("midrst_ep",     32'(ep_v[0]),     32'h0);
    check_val("midrst_es",     32'(es_v[0]),     32'h0);
    check_val("midrst_ocup",   32'(ocup_v[0]),   32'h0);
    check_val("midrst_state",  32'(st_a[0]),     32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    hold(0, 1'b1, 200);
    verify_events("midrst");
    send_frame(0, 9'h081, 1'b0, 2'b11, 20);
    verify_events("after_rst");

    // random frames on every configuration
    for (int d = 0; d < NDUT; d++) begin
      c0 = 0;
      for (int k = 0; k < 12; k++) begin
        data  = 9'($urandom);
        pbit  = 1'($urandom);
        stops = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
        gap   = $urandom_range(0, 3);
        if (!stops[cfg_stop(d) - 1] && gap == 0) gap = 1;
        send_frame(d, data, pbit, stops, gap);
        c0++;
      end
      hold(d, 1'b1, 3 * cfg_cpb(d));
      verify_events($sformatf("rand%0d", d));
      check_val($sformatf("rand%0d_idle_state", d), 32'(st_a[d]), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
